// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS_DEFAULT  = 8;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned div;
    div = clk_hz / (baud * os);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running divider producing a one-clock oversample tick every DIV clocks.
module uart_rx_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt_q, r_cnt_d;
  logic          w_tick;

  assign w_tick = (r_cnt_q == CW'(DIV - 1));
  assign o_tick = w_tick;

  always_comb begin
    r_cnt_d = r_cnt_q + CW'(1);
    if (w_tick) r_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt_q <= '0;
    else        r_cnt_q <= r_cnt_d;
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// Oversampling 8N1 UART receiver; define UART_RX_PARITY_EN for 8E1 frames with even parity check.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data_out,
  output logic                 o_data_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  localparam uart_state_e AfterData = PARITY;
`else
  localparam uart_state_e AfterData = STOP;
`endif

  logic [1:0]           r_sync_q;
  logic                 r_rxs_prev_q;
  uart_state_e          r_state_q, r_state_d;
  logic [SW-1:0]        r_samp_q, r_samp_d;
  logic [BW-1:0]        r_bit_q, r_bit_d;
  logic [DATA_BITS-1:0] r_shift_q, r_shift_d;
  logic [DATA_BITS-1:0] r_data_q, r_data_d;
  logic                 r_valid_q, r_valid_d;
  logic                 r_ferr_q, r_ferr_d;

  logic w_tick, w_rxs, w_fall, w_half, w_full, w_par_ok;

  uart_rx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_rxs  = r_sync_q[1];
  assign w_fall = r_rxs_prev_q & ~w_rxs;
  assign w_half = (r_samp_q == SW'(OVERSAMPLE / 2 - 1));
  assign w_full = (r_samp_q == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_q     <= 2'b11;
      r_rxs_prev_q <= 1'b1;
    end else begin
      r_sync_q     <= {r_sync_q[0], i_rx};
      r_rxs_prev_q <= w_rxs;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_par_q <= 1'b0;
    else if (r_state_q == PARITY && w_tick && w_full) r_par_q <= w_rxs;
  end

  assign w_par_ok = ~(^{r_shift_q, r_par_q});
`else
  assign w_par_ok = 1'b1;
`endif

  always_comb begin
    r_state_d = r_state_q;
    r_samp_d  = r_samp_q;
    r_bit_d   = r_bit_q;
    r_shift_d = r_shift_q;
    r_data_d  = r_data_q;
    r_valid_d = 1'b0;
    r_ferr_d  = 1'b0;

    unique case (r_state_q)
      IDLE: begin
        // Only a genuine 1->0 edge starts a frame, so a held-low line cannot retrigger.
        if (w_fall) begin
          r_state_d = START;
          r_samp_d  = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (w_half) begin
            r_samp_d = '0;
            r_bit_d  = '0;
            r_state_d = w_rxs ? IDLE : DATA;
          end else begin
            r_samp_d = r_samp_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (w_full) begin
            r_samp_d  = '0;
            r_shift_d = {w_rxs, r_shift_q[DATA_BITS-1:1]};
            if (r_bit_q == BW'(DATA_BITS - 1)) begin
              r_bit_d   = '0;
              r_state_d = AfterData;
            end else begin
              r_bit_d = r_bit_q + BW'(1);
            end
          end else begin
            r_samp_d = r_samp_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          if (w_full) begin
            r_samp_d  = '0;
            r_state_d = STOP;
          end else begin
            r_samp_d = r_samp_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (w_full) begin
            r_samp_d  = '0;
            r_state_d = IDLE;
            if (w_rxs && w_par_ok) begin
              r_data_d  = r_shift_q;
              r_valid_d = 1'b1;
            end else begin
              r_ferr_d = 1'b1;
            end
          end else begin
            r_samp_d = r_samp_q + SW'(1);
          end
        end
      end
      default: r_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= IDLE;
      r_samp_q  <= '0;
      r_bit_q   <= '0;
      r_shift_q <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_ferr_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_samp_q  <= r_samp_d;
      r_bit_q   <= r_bit_d;
      r_shift_q <= r_shift_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      r_ferr_q  <= r_ferr_d;
    end
  end

  assign o_data_out   = r_data_q;
  assign o_data_valid = r_valid_q;
  assign o_frame_err  = r_ferr_q;
  assign o_busy       = (r_state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm at 16 clocks per bit (DIV = 1).
module tb_uart_rx_fsm;

  localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  logic       clk, rst_n, rx;
  logic [7:0] data_out;
  logic       data_valid, frame_err, busy;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t       sb[$];
  int         n_tests, n_fail, cyc, prev_pulse, last_pulse;
  logic [7:0] last_good;

  uart_rx_fsm #(
    .CLK_FREQ_HZ (1_600_000),
    .BAUD        (100_000),
    .OVERSAMPLE  (16),
    .DATA_BITS   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx),
    .o_data_out   (data_out),
    .o_data_valid (data_valid),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses are popped against the scoreboard; latency must land in the stop bit's second half.
  initial begin
    exp_t e;
    int   dt;
    forever begin
      @(negedge clk);
      if (rst_n && (data_valid || frame_err)) begin
        check_eq("pulse_exclusive", {31'b0, data_valid & frame_err}, 32'd0);
        check_eq("pulse_expected", {31'b0, sb.size() != 0}, 32'd1);
        prev_pulse = last_pulse;
        last_pulse = cyc;
        if (sb.size() != 0) begin
          e  = sb.pop_front();
          dt = cyc - e.start;
          check_eq("pulse_kind", {31'b0, frame_err}, {31'b0, e.err});
          check_eq("data_out", {24'b0, data_out}, {24'b0, e.data});
          check_eq("pulse_latency",
                   {31'b0, (dt >= (FRAME_BITS - 1) * BIT_CLKS + 8) && (dt < FRAME_CLKS)}, 32'd1);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    exp_t e;
    logic good;
    good = stop_bit;
`ifdef UART_RX_PARITY_EN
    good = stop_bit & ~par_flip;
`endif
    e.err   = ~good;
    e.data  = good ? d : last_good;
    e.start = cyc;
    if (good) last_good = d;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic wait_drain(input int max_clks);
    for (int i = 0; i < max_clks && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", sb.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, {24'b0, data_out}, 32'd0);
    check_eq({tag, "_valid"}, {31'b0, data_valid}, 32'd0);
    check_eq({tag, "_ferr"}, {31'b0, frame_err}, 32'd0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    n_tests    = 0;
    n_fail     = 0;
    prev_pulse = 0;
    last_pulse = 0;
    last_good  = 8'h00;
    rst_n      = 1'b0;
    rx         = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain(40);
    check_eq("busy_after_a5", {31'b0, busy}, 32'd0);
    check_eq("hold_a5", {24'b0, data_out}, 32'h0000_00A5);
    repeat (10) @(negedge clk);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_drain(40);
    check_eq("b2b_spacing", last_pulse - prev_pulse, FRAME_CLKS);
    repeat (10) @(negedge clk);

    // Short low glitch: busy rises, then falls at the mid-start sample.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("glitch_busy_hi", {31'b0, busy}, 32'd1);
    repeat (8) @(negedge clk);
    check_eq("glitch_busy_lo", {31'b0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Bad stop bit, then line held low (break) before returning idle.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    check_eq("break_busy", {31'b0, busy}, 32'd0);
    rx = 1'b1;
    wait_drain(40);
    check_eq("hold_after_ferr", {24'b0, data_out}, {24'b0, last_good});
    repeat (32) @(negedge clk);

    // Reset in the middle of bit 4 of 0x81.
    d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rx = 1'b1;
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain(40);
    check_eq("after_reset_81", {24'b0, data_out}, 32'h0000_0081);
    repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    wait_drain(40);
    repeat (10) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    wait_drain(40);
    repeat (10) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
